// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode constants and sequencer state encoding
package cpu_defs;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T1W   = 4'd3,
    S_T2    = 4'd4,
    S_T3    = 4'd5,
    S_T4    = 4'd6,
    S_T5    = 4'd7,
    S_T6    = 4'd8,
    S_T7    = 4'd9,
    S_T7W   = 4'd10,
    S_HALT  = 4'd11
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore fetch/decode/execute control FSM
module control_sequencer
  import cpu_defs::*;
(
  input  logic       Clock,
  input  logic       clear,
  input  logic [4:0] ir_op,
  input  logic       memory_done,
  output logic       PCout,
  output logic       Zlo_out,
  output logic       Zhi_out,
  output logic       MDRout,
  output logic       HIout,
  output logic       LOout,
  output logic       Cout,
  output logic       Inport_out,
  output logic       MARin,
  output logic       Zin,
  output logic       PCin,
  output logic       MDRin,
  output logic       IRin,
  output logic       Yin,
  output logic       HIin,
  output logic       LOin,
  output logic       CONin,
  output logic       outport_in,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       IncPC,
  output logic [4:0] opcode,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       Mem_enable512x32,
  output logic       run
);

  state_t state, state_next;

  always_ff @(posedge Clock) begin
    if (!clear) state <= S_RESET;
    else        state <= state_next;
  end

  // ir_op comes from the IR register, so it is stable for the whole instruction
  always_comb begin
    state_next       = state;
    PCout            = 1'b0;
    Zlo_out          = 1'b0;
    Zhi_out          = 1'b0;
    MDRout           = 1'b0;
    HIout            = 1'b0;
    LOout            = 1'b0;
    Cout             = 1'b0;
    Inport_out       = 1'b0;
    MARin            = 1'b0;
    Zin              = 1'b0;
    PCin             = 1'b0;
    MDRin            = 1'b0;
    IRin             = 1'b0;
    Yin              = 1'b0;
    HIin             = 1'b0;
    LOin             = 1'b0;
    CONin            = 1'b0;
    outport_in       = 1'b0;
    Gra              = 1'b0;
    Grb              = 1'b0;
    Grc              = 1'b0;
    Rin              = 1'b0;
    Rout             = 1'b0;
    BAout            = 1'b0;
    IncPC            = 1'b0;
    opcode           = 5'b00000;
    Mem_Read         = 1'b0;
    Mem_Write        = 1'b0;
    Mem_enable512x32 = 1'b0;
    run              = (state != S_RESET) && (state != S_HALT);

    case (state)
      S_RESET: state_next = S_T0;
      S_T0: begin
        PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        Zlo_out = 1'b1; PCin = 1'b1; MDRin = 1'b1;
        Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        state_next = memory_done ? S_T2 : S_T1W;
      end
      S_T1W: begin
        MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        state_next = memory_done ? S_T2 : S_T1W;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        state_next = S_T0;
        if (is_alu_op(ir_op)) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_next = S_T4;
        end else if (is_mem_op(ir_op) || ir_op == OP_LDI) begin
          Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1;
          state_next = S_T4;
        end else if (ir_op == OP_MFHI) begin
          Gra = 1'b1; HIout = 1'b1; Rin = 1'b1;
        end else if (ir_op == OP_MFLO) begin
          Gra = 1'b1; LOout = 1'b1; Rin = 1'b1;
        end else if (ir_op == OP_HALT) begin
          state_next = S_HALT;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        if (is_alu_op(ir_op)) begin
          Grc = 1'b1; Rout = 1'b1; opcode = ir_op;
        end else begin
          Cout = 1'b1; opcode = OP_ADD;
        end
        state_next = S_T5;
      end
      S_T5: begin
        Zlo_out = 1'b1;
        if (is_mem_op(ir_op)) begin
          MARin = 1'b1;
          state_next = S_T6;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
          state_next = S_T0;
        end
      end
      S_T6: begin
        if (ir_op == OP_LD) begin
          MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
          state_next = memory_done ? S_T7 : S_T6;
        end else begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          state_next = S_T7;
        end
      end
      S_T7: begin
        if (ir_op == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_next = S_T0;
        end else begin
          Mem_Write = 1'b1; Mem_enable512x32 = 1'b1;
          state_next = memory_done ? S_T0 : S_T7W;
        end
      end
      S_T7W: begin
        Mem_Write = 1'b1; Mem_enable512x32 = 1'b1;
        state_next = memory_done ? S_T0 : S_T7W;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic clear = 1'b0;
  logic [4:0] ir_op = 5'b00011;
  logic memory_done = 1'b1;
  logic PCout, Zlo_out, Zhi_out, MDRout, HIout, LOout, Cout, Inport_out;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
  logic [4:0] opcode;
  logic Mem_Read, Mem_Write, Mem_enable512x32, run;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .ir_op(ir_op), .memory_done(memory_done),
    .PCout(PCout), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .Inport_out(Inport_out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .IncPC(IncPC), .opcode(opcode), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32), .run(run)
  );

  always #5 Clock = ~Clock;

  logic [33:0] outs;
  assign outs = {run, Mem_enable512x32, Mem_Write, Mem_Read, opcode, IncPC, BAout,
                 Rout, Rin, Grc, Grb, Gra, outport_in, CONin, LOin, HIin, Yin, IRin,
                 MDRin, PCin, Zin, MARin, Inport_out, Cout, LOout, HIout, MDRout,
                 Zhi_out, Zlo_out, PCout};

  localparam logic [33:0] B = 34'h1;
  localparam logic [33:0] M_PCOUT = B << 0,  M_ZLO = B << 1,   M_MDROUT = B << 3;
  localparam logic [33:0] M_HIOUT = B << 4,  M_LOOUT = B << 5, M_COUT = B << 6;
  localparam logic [33:0] M_MARIN = B << 8,  M_ZIN = B << 9,   M_PCIN = B << 10;
  localparam logic [33:0] M_MDRIN = B << 11, M_IRIN = B << 12, M_YIN = B << 13;
  localparam logic [33:0] M_GRA = B << 18,   M_GRB = B << 19,  M_GRC = B << 20;
  localparam logic [33:0] M_RIN = B << 21,   M_ROUT = B << 22, M_BAOUT = B << 23;
  localparam logic [33:0] M_INCPC = B << 24, M_MRD = B << 30,  M_MWR = B << 31;
  localparam logic [33:0] M_MEN = B << 32,   M_RUN = B << 33;

  localparam logic [33:0] E_T0   = M_RUN | M_PCOUT | M_INCPC | M_MARIN | M_ZIN;
  localparam logic [33:0] E_T1   = M_RUN | M_ZLO | M_PCIN | M_MDRIN | M_MRD | M_MEN;
  localparam logic [33:0] E_T1W  = M_RUN | M_MDRIN | M_MRD | M_MEN;
  localparam logic [33:0] E_T2   = M_RUN | M_MDROUT | M_IRIN;
  localparam logic [33:0] E_ALU3 = M_RUN | M_GRB | M_ROUT | M_YIN;
  localparam logic [33:0] E_IMM3 = M_RUN | M_GRB | M_ROUT | M_BAOUT | M_YIN;
  localparam logic [33:0] E_IMM4 = M_RUN | M_COUT | M_ZIN | {4'b0, 5'b00011, 25'b0};
  localparam logic [33:0] E_WB5  = M_RUN | M_ZLO | M_GRA | M_RIN;
  localparam logic [33:0] E_MAR5 = M_RUN | M_ZLO | M_MARIN;
  localparam logic [33:0] E_LD6  = M_RUN | M_MDRIN | M_MRD | M_MEN;
  localparam logic [33:0] E_LD7  = M_RUN | M_MDROUT | M_GRA | M_RIN;
  localparam logic [33:0] E_ST6  = M_RUN | M_GRA | M_ROUT | M_MDRIN;
  localparam logic [33:0] E_ST7  = M_RUN | M_MWR | M_MEN;
  localparam logic [33:0] E_RUN  = M_RUN;
  localparam logic [33:0] E_ZERO = 34'h0;

  function automatic logic [33:0] alu4(input logic [4:0] op);
    return M_RUN | M_GRC | M_ROUT | M_ZIN | {4'b0, op, 25'b0};
  endfunction

  logic [33:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // Drive this cycle's inputs just after the edge and queue the outputs expected in it.
  task automatic step(input logic clr, input logic md, input logic [4:0] op,
                      input logic [33:0] e, input string nm);
    @(posedge Clock);
    #1;
    clear = clr;
    memory_done = md;
    ir_op = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch(input logic [4:0] op);
    step(1'b1, 1'b1, op, E_T0, "t0");
    step(1'b1, 1'b1, op, E_T1, "t1");
    step(1'b1, 1'b1, op, E_T2, "t2");
  endtask

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      logic [33:0] e;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, outs, e);
      end
    end
  end

  initial begin
    // reset held, then released with ADD and memory_done=1
    step(1'b0, 1'b1, 5'b00011, E_ZERO, "reset_held");
    step(1'b1, 1'b1, 5'b00011, E_ZERO, "reset_release");
    fetch(5'b00011);
    step(1'b1, 1'b1, 5'b00011, E_ALU3, "add_t3");
    step(1'b1, 1'b1, 5'b00011, alu4(5'b00011), "add_t4");
    step(1'b1, 1'b1, 5'b00011, E_WB5, "add_t5");

    // MFHI with a slow fetch: T1 plus three T1W cycles
    step(1'b1, 1'b0, 5'b11000, E_T0, "mfhi_t0");
    step(1'b1, 1'b0, 5'b11000, E_T1, "mfhi_t1");
    step(1'b1, 1'b0, 5'b11000, E_T1W, "mfhi_t1w_a");
    step(1'b1, 1'b0, 5'b11000, E_T1W, "mfhi_t1w_b");
    step(1'b1, 1'b1, 5'b11000, E_T1W, "mfhi_t1w_c");
    step(1'b1, 1'b1, 5'b11000, E_T2, "mfhi_t2");
    step(1'b1, 1'b1, 5'b11000, M_RUN | M_GRA | M_HIOUT | M_RIN, "mfhi_t3");

    fetch(5'b11001);
    step(1'b1, 1'b1, 5'b11001, M_RUN | M_GRA | M_LOOUT | M_RIN, "mflo_t3");

    fetch(5'b00001);
    step(1'b1, 1'b1, 5'b00001, E_IMM3, "ldi_t3");
    step(1'b1, 1'b1, 5'b00001, E_IMM4, "ldi_t4");
    step(1'b1, 1'b1, 5'b00001, E_WB5, "ldi_t5");

    fetch(5'b00101);
    step(1'b1, 1'b1, 5'b00101, E_ALU3, "and_t3");
    step(1'b1, 1'b1, 5'b00101, alu4(5'b00101), "and_t4");
    step(1'b1, 1'b1, 5'b00101, E_WB5, "and_t5");

    fetch(5'b00000);
    step(1'b1, 1'b1, 5'b00000, E_IMM3, "ld_t3");
    step(1'b1, 1'b1, 5'b00000, E_IMM4, "ld_t4");
    step(1'b1, 1'b1, 5'b00000, E_MAR5, "ld_t5");
    step(1'b1, 1'b1, 5'b00000, E_LD6, "ld_t6");
    step(1'b1, 1'b1, 5'b00000, E_LD7, "ld_t7");

    // ST with memory_done low for T7 and one T7W
    fetch(5'b00010);
    step(1'b1, 1'b1, 5'b00010, E_IMM3, "st_t3");
    step(1'b1, 1'b1, 5'b00010, E_IMM4, "st_t4");
    step(1'b1, 1'b1, 5'b00010, E_MAR5, "st_t5");
    step(1'b1, 1'b1, 5'b00010, E_ST6, "st_t6");
    step(1'b1, 1'b0, 5'b00010, E_ST7, "st_t7");
    step(1'b1, 1'b0, 5'b00010, E_ST7, "st_t7w_a");
    step(1'b1, 1'b1, 5'b00010, E_ST7, "st_t7w_b");

    fetch(5'b10101);
    step(1'b1, 1'b1, 5'b10101, E_RUN, "undef_t3");
    fetch(5'b11010);
    step(1'b1, 1'b1, 5'b11010, E_RUN, "nop_t3");

    fetch(5'b11011);
    step(1'b1, 1'b1, 5'b11011, E_RUN, "halt_t3");
    for (int i = 0; i < 20; i++) step(1'b1, i[0], 5'b11011, E_ZERO, "halt_hold");

    // leave HALT via reset, then abort an LD waiting in T6
    step(1'b0, 1'b1, 5'b00000, E_ZERO, "halt_clear");
    step(1'b1, 1'b1, 5'b00000, E_ZERO, "halt_release");
    fetch(5'b00000);
    step(1'b1, 1'b1, 5'b00000, E_IMM3, "ld2_t3");
    step(1'b1, 1'b1, 5'b00000, E_IMM4, "ld2_t4");
    step(1'b1, 1'b1, 5'b00000, E_MAR5, "ld2_t5");
    step(1'b1, 1'b0, 5'b00000, E_LD6, "ld2_t6");
    step(1'b0, 1'b0, 5'b00000, E_LD6, "ld2_t6_wait");
    step(1'b1, 1'b1, 5'b00000, E_ZERO, "ld2_reset");
    step(1'b1, 1'b1, 5'b00000, E_T0, "ld2_t0_after");

    repeat (3) @(posedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset; synchronous, active-low.
- ir_op  in  5  IR[31:27]; valid from the cycle after IRin.
- memory_done  in  1  memory completes the current Mem_Read/Mem_Write.
- PCout, Zlo_out, Zhi_out, MDRout, HIout, LOout, Cout, Inport_out  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in  out  1 each  register load enables.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select and register-file controls.
- IncPC  out  1  ALU PC+1 select.
- opcode  out  5  ALU operation.
- Mem_Read, Mem_Write, Mem_enable512x32  out  1 each  memory controls.
- run  out  1  high while executing; low in HALT and RESET.

Function
REQ-002 The block SHALL be a Moore FSM; every output SHALL be a pure decode of the state register.
REQ-003 Any output not listed for the current state SHALL be 0; opcode SHALL be 5'b00000 unless a state specifies a value.
REQ-004 States: RESET, T0, T1, T1W, T2, T3, T4, T5, T6, T7, T7W, HALT.
REQ-005 Fetch outputs:
- T0: PCout, IncPC, MARin, Zin.
- T1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32.
- T1W: MDRin, Mem_Read, Mem_enable512x32 only; PCin SHALL NOT repeat.
- T2: MDRout, IRin.
REQ-006 Fetch transitions:
- T0->T1.
- T1->T2 if memory_done=1, else T1->T1W.
- T1W->T1W until memory_done=1, then ->T2.
- T2->T3.
REQ-007 In T3 the block SHALL decode ir_op using the package constants: LD 00000, LDI 00001, ST 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, MFHI 11000, MFLO 11001, NOP 11010, HALT 11011.
REQ-008 ADD/SUB/AND/OR:
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, Zin, opcode=ir_op.
- T5: Zlo_out, Gra, Rin.
- Then ->T0.
REQ-009 LDI:
- T3: Grb, Rout, BAout, Yin.
- T4: Cout, Zin, opcode=ADD.
- T5: Zlo_out, Gra, Rin.
- Then ->T0.
REQ-010 LD:
- T3 and T4 as LDI.
- T5: Zlo_out, MARin.
- T6: MDRin, Mem_Read, Mem_enable512x32; wait in T6 until memory_done=1.
- T7: MDRout, Gra, Rin.
- Then ->T0.
REQ-011 ST:
- T3 and T4 as LDI.
- T5: Zlo_out, MARin.
- T6: Gra, Rout, MDRin.
- T7: Mem_Write, Mem_enable512x32.
- T7W: holds the T7 outputs until memory_done=1.
- Then ->T0.
REQ-012 MFHI SHALL execute T3: Gra, HIout, Rin; MFLO SHALL execute T3: Gra, LOout, Rin; both SHALL then go to T0.
REQ-013 NOP and any undefined ir_op SHALL go T3->T0 with all T3 outputs 0.
REQ-014 HALT SHALL go T3->HALT; HALT SHALL hold all outputs 0 and run=0 until reset.
REQ-015 Minimum latencies with memory_done=1 in its first sampled cycle: fetch 3 cycles; MFHI/MFLO 4; ALU and LDI 6; LD and ST 8.
REQ-016 memory_done SHALL be ignored outside T1, T1W, T6, T7 and T7W.

Reset
REQ-017 clear=0 at a rising edge SHALL force RESET from any state, including mid-wait states; all outputs 0 and run=0.
REQ-018 RESET SHALL go to T0 on the first edge with clear=1.

Structure
REQ-019 The opcode constants and state encodings SHALL live in a shared package (cpu_defs), which the ALU also uses.
REQ-020 The block SHALL be one module with no sub-modules; state register and output decode in separate processes.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release with ir_op=ADD, memory_done=1: T0 occurs in the first cycle after release; T0 outputs PCout=IncPC=MARin=Zin=1; PCin pulses exactly once per fetch.
- Fetch with memory_done=1 after 3 cycles in T1W, ir_op=MFHI: Mem_Read is high 4 cycles; IRin pulses once; the following cycle shows Gra=HIout=Rin=1; then T0.
- ir_op=LDI: T4 shows Cout=1, Zin=1, opcode=00011; T5 shows Zlo_out=1, Gra=1, Rin=1; 6 cycles total.
- ir_op=ST with memory_done low for 2 cycles in T7: Mem_Write is high 3 cycles; the next state is T0.
- ir_op=5'b10101 (undefined): acts as NOP, 4 cycles; ir_op=HALT: run=0 and all outputs stay 0 for 20 cycles.
- clear=0 during T6 of LD: all outputs 0 the next cycle; T0 follows one cycle after clear=1.
